mux_sel_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the 2:1 select mux on the Mimas V2 board. It synchronises the two DIP-switch data bits and one push button into the 100 MHz domain. It debounces the button and toggles a registered select bit on each clean press. It drives the mux data and select inputs with glitch-free, registered signals.

---
 rtl/mux_sel_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/mux_sel_conditioner.sv | 100 ++++++++++
 tb/tb_mux_sel_conditioner.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the mux select conditioner.
// Holds the debounce FSM state encoding and the board clock figures.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int CLK_HZ              = 100_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Both stages reset to RESET_VAL so downstream logic sees a defined level.
module sync_2ff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mux_sel_conditioner.sv
// Conditions the Mimas V2 DIP switches and push button for the 2:1 select mux:
// synchronised data bits plus a debounced, press-toggled registered select.
module mux_sel_conditioner
    import mux_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_i,
    input  logic [1:0] sw_i,
    output logic [1:0] data_o,
    output logic       sel_o,
    output logic       press_o
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0]       BTN_IDLE = BTN_ACTIVE_LOW;

    logic [0:0]       btn_q;
    logic             btn_s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sel_nxt;
    logic             press_nxt;

    // Button flops rest at the raw idle level so reset never looks like a press.
    sync_2ff #(.WIDTH(1), .RESET_VAL(BTN_IDLE)) u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_i),
        .q   (btn_q)
    );

    sync_2ff #(.WIDTH(2), .RESET_VAL(2'b00)) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw_i),
        .q   (data_o)
    );

    assign btn_s = btn_q[0] ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_o   <= 1'b0;
            press_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sel_o   <= sel_nxt;
            press_o <= press_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (btn_s) state_nxt = PRESS_WAIT;
            PRESS_WAIT:   if (!btn_s) state_nxt = IDLE;
                          else if (cnt == CNT_MAX) state_nxt = PRESSED;
            PRESSED:      if (!btn_s) state_nxt = RELEASE_WAIT;
            RELEASE_WAIT: if (btn_s) state_nxt = PRESSED;
                          else if (cnt == CNT_MAX) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // The counter is cleared on every exit, so it never reaches DEBOUNCE_CYCLES.
    always_comb begin
        cnt_nxt   = cnt;
        sel_nxt   = sel_o;
        press_nxt = 1'b0;
        case (state)
            IDLE:    cnt_nxt = '0;
            PRESS_WAIT: begin
                if (!btn_s) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_MAX) begin
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                    sel_nxt   = ~sel_o;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: cnt_nxt = '0;
            RELEASE_WAIT: begin
                if (btn_s || cnt == CNT_MAX) cnt_nxt = '0;
                else                         cnt_nxt = cnt + CNT_W'(1);
            end
            default: cnt_nxt = '0;
        endcase
    end

endmodule

// File: tb/tb_mux_sel_conditioner.sv
// Scoreboard bench for mux_sel_conditioner with DEBOUNCE_CYCLES=4, active-low button.
// Stimulus queues expected press/data events; a negedge monitor pops and compares.
module tb_mux_sel_conditioner;

    logic       clk;
    logic       rst;
    logic       btn_i;
    logic [1:0] sw_i;
    logic [1:0] data_o;
    logic       sel_o;
    logic       press_o;

    int   cyc;
    int   n_checks;
    int   n_pass;
    bit   mon_en;
    logic [1:0] prev_data;

    int         press_cyc_q[$];
    bit         press_sel_q[$];
    int         data_cyc_q[$];
    logic [1:0] data_val_q[$];

    mux_sel_conditioner #(.DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b1)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_i),
        .sw_i    (sw_i),
        .data_o  (data_o),
        .sel_o   (sel_o),
        .press_o (press_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_press(input int at_cyc, input bit sel);
        press_cyc_q.push_back(at_cyc);
        press_sel_q.push_back(sel);
    endtask

    task automatic expect_data(input int at_cyc, input logic [1:0] val);
        data_cyc_q.push_back(at_cyc);
        data_val_q.push_back(val);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (press_o !== 1'b0) begin
                if (press_cyc_q.size() == 0) begin
                    check("press_spurious", 32'(press_o), 32'd0);
                end else begin
                    check("press_cycle", cyc, press_cyc_q.pop_front());
                    check("press_sel", 32'(sel_o), 32'(press_sel_q.pop_front()));
                end
            end
            if (data_o !== prev_data) begin
                if (data_cyc_q.size() == 0) begin
                    check("data_spurious", 32'(data_o), 32'(prev_data));
                end else begin
                    check("data_cycle", cyc, data_cyc_q.pop_front());
                    check("data_value", 32'(data_o), 32'(data_val_q.pop_front()));
                end
                prev_data = data_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        n_checks  = 0;
        n_pass    = 0;
        mon_en    = 1'b0;
        prev_data = 2'b00;
        rst       = 1'b0;
        btn_i     = 1'b1;
        sw_i      = 2'b00;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_sel", 32'(sel_o), 32'd0);
        check("rst_press", 32'(press_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        wait_cyc(3);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Switches: two-edge latency
        wait_cyc(1);
        k = cyc + 1; sw_i = 2'b10; expect_data(k + 1, 2'b10);
        wait_cyc(4);
        k = cyc + 1; sw_i = 2'b01; expect_data(k + 1, 2'b01);
        wait_cyc(4);

        // Clean press, held 50 cycles
        k = cyc + 1; btn_i = 1'b0; expect_press(k + 6, 1'b1);
        wait_cyc(50);

        // Release bounce, then a second clean press toggles back
        btn_i = 1'b1; wait_cyc(2);
        btn_i = 1'b0; wait_cyc(2);
        btn_i = 1'b1; wait_cyc(12);
        k = cyc + 1; btn_i = 1'b0; expect_press(k + 6, 1'b0);
        wait_cyc(10);
        btn_i = 1'b1; wait_cyc(12);

        // Press bounce rejection
        btn_i = 1'b0; wait_cyc(3);
        btn_i = 1'b1; wait_cyc(1);
        btn_i = 1'b0; wait_cyc(3);
        btn_i = 1'b1; wait_cyc(8);
        check("bounce_sel", 32'(sel_o), 32'd0);
        check("bounce_state", 32'(u_dut.state), 32'd0);

        // Set sel to 1 so the mid-debounce reset visibly clears it
        k = cyc + 1; btn_i = 1'b0; expect_press(k + 6, 1'b1);
        wait_cyc(10);
        btn_i = 1'b1; wait_cyc(12);
        k = cyc + 1; sw_i = 2'b00; expect_data(k + 1, 2'b00);
        wait_cyc(4);

        // Reset while in PRESS_WAIT with cnt=2
        k = cyc + 1; btn_i = 1'b0;
        wait_cyc(5);
        check("mid_state", 32'(u_dut.state), 32'd1);
        check("mid_cnt", 32'(u_dut.cnt), 32'd2);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_sel", 32'(sel_o), 32'd0);
        check("mid_rst_press", 32'(press_o), 32'd0);
        check("mid_rst_state", 32'(u_dut.state), 32'd0);
        wait_cyc(3);
        rst = 1'b0;
        k = cyc + 1; expect_press(k + 6, 1'b1);
        wait_cyc(20);
        btn_i = 1'b1; wait_cyc(12);

        check("press_pending", press_cyc_q.size(), 32'd0);
        check("data_pending", data_cyc_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
